// File: rtl/external_bus_responder.sv
// rtl/external_bus_responder.sv - paged register bank on the CPU external bus with programmable wait states
module external_bus_responder #(
    parameter logic [7:0] pageAddress  = 8'hD0,
    parameter int         numRegisters = 16,
    parameter int         waitStates   = 2,
    parameter logic [7:0] resetValue   = 8'h00
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] addressBusHigh,
    input  logic [7:0] addressBusLow,
    input  logic       busCycleValid,
    input  logic       readNotWrite,
    input  logic [7:0] dataBusIn,
    output logic [7:0] dataBusOut,
    output logic       dataBusOutEnable,
    output logic       ready,
    output logic       writeStrobe,
    output logic [((numRegisters > 1) ? $clog2(numRegisters) : 1)-1:0] writeIndex
);
    localparam int         IW        = (numRegisters > 1) ? $clog2(numRegisters) : 1;
    localparam logic [7:0] IDX_MASK  = 8'(numRegisters - 1);
    // The request cycle already counts as the first low-ready cycle.
    localparam logic [3:0] WAIT_LOAD = (waitStates >= 2) ? 4'(waitStates - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    wait_count;
    logic [3:0]    count_next;
    logic [IW-1:0] lat_idx;
    logic          lat_rnw;
    logic [IW-1:0] req_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] commit_idx;
    logic          latch_req;
    logic          commit;
    logic          out_en;
    logic          hit;
    logic [7:0]    bank [numRegisters];

    assign hit = busCycleValid
              && (addressBusHigh == pageAddress)
              && ((addressBusLow & ~IDX_MASK) == 8'h00);
    assign req_idx = IW'(addressBusLow & IDX_MASK);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            wait_count <= 4'd0;
        end else begin
            state      <= state_next;
            wait_count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = wait_count;
        latch_req  = 1'b0;
        commit     = 1'b0;
        commit_idx = lat_idx;
        out_en     = 1'b0;
        rd_idx     = lat_idx;
        ready      = 1'b1;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    if (waitStates == 0) begin
                        if (readNotWrite) begin
                            out_en = 1'b1;
                            rd_idx = req_idx;
                        end else begin
                            commit     = 1'b1;
                            commit_idx = req_idx;
                        end
                    end else begin
                        ready     = 1'b0;
                        latch_req = 1'b1;
                        if (waitStates == 1) begin
                            state_next = S_ACCESS;
                        end else begin
                            state_next = S_WAIT;
                            count_next = WAIT_LOAD;
                        end
                    end
                end
            end
            S_WAIT: begin
                ready = 1'b0;
                if (!busCycleValid) begin
                    state_next = S_IDLE;
                    count_next = 4'd0;
                end else if (wait_count == 4'd0) begin
                    state_next = S_ACCESS;
                end else begin
                    count_next = wait_count - 4'd1;
                end
            end
            S_ACCESS: begin
                state_next = S_IDLE;
                if (lat_rnw) begin
                    out_en = 1'b1;
                end else begin
                    commit = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = 4'd0;
            end
        endcase
        // A CPU still presenting a hit while reset is held must not see a stall.
        if (!nrst) begin
            ready  = 1'b1;
            out_en = 1'b0;
        end
        dataBusOutEnable = out_en;
        dataBusOut       = out_en ? bank[rd_idx] : 8'h00;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lat_idx     <= '0;
            lat_rnw     <= 1'b0;
            writeStrobe <= 1'b0;
            writeIndex  <= '0;
            for (int i = 0; i < numRegisters; i++) begin
                bank[i] <= resetValue;
            end
        end else begin
            if (latch_req) begin
                lat_idx <= req_idx;
                lat_rnw <= readNotWrite;
            end
            writeStrobe <= commit;
            if (commit) begin
                bank[commit_idx] <= dataBusIn;
                writeIndex       <= commit_idx;
            end
        end
    end

endmodule

// File: tb/tb_external_bus_responder.sv
// tb/tb_external_bus_responder.sv - bench for external_bus_responder with 2, 0 and 1 wait-state instances
module tb_external_bus_responder;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] hi = 8'h00;
    logic [7:0] lo = 8'h00;
    logic [7:0] din = 8'h00;
    logic       valid = 1'b0;
    logic       rnw = 1'b0;
    int         sel = 0;

    logic [7:0] dout0, dout1, dout2, dout;
    logic       oe0, oe1, oe2, oe;
    logic       rdy0, rdy1, rdy2, rdy;
    logic       stb0, stb1, stb2, stb;
    logic [3:0] wi0, wi1, wi2, wi;

    int         ws_tab [3] = '{2, 0, 1};
    logic [7:0] m_bank [3][16];
    logic [3:0] m_widx [3];
    logic       m_strobe;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    external_bus_responder #(.waitStates(2)) u_ws2 (
        .clk(clk), .nrst(nrst), .addressBusHigh(hi), .addressBusLow(lo),
        .busCycleValid(valid && (sel == 0)), .readNotWrite(rnw), .dataBusIn(din),
        .dataBusOut(dout0), .dataBusOutEnable(oe0), .ready(rdy0),
        .writeStrobe(stb0), .writeIndex(wi0)
    );
    external_bus_responder #(.waitStates(0)) u_ws0 (
        .clk(clk), .nrst(nrst), .addressBusHigh(hi), .addressBusLow(lo),
        .busCycleValid(valid && (sel == 1)), .readNotWrite(rnw), .dataBusIn(din),
        .dataBusOut(dout1), .dataBusOutEnable(oe1), .ready(rdy1),
        .writeStrobe(stb1), .writeIndex(wi1)
    );
    external_bus_responder #(.waitStates(1)) u_ws1 (
        .clk(clk), .nrst(nrst), .addressBusHigh(hi), .addressBusLow(lo),
        .busCycleValid(valid && (sel == 2)), .readNotWrite(rnw), .dataBusIn(din),
        .dataBusOut(dout2), .dataBusOutEnable(oe2), .ready(rdy2),
        .writeStrobe(stb2), .writeIndex(wi2)
    );

    always_comb begin
        case (sel)
            1:       begin dout = dout1; oe = oe1; rdy = rdy1; stb = stb1; wi = wi1; end
            2:       begin dout = dout2; oe = oe2; rdy = rdy2; stb = stb2; wi = wi2; end
            default: begin dout = dout0; oe = oe0; rdy = rdy0; stb = stb0; wi = wi0; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (ws=%0d): observed 0x%0h expected 0x%0h", tag, ws_tab[sel], obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_widx[i] = 4'd0;
            for (int j = 0; j < 16; j++) m_bank[i][j] = 8'h00;
        end
        m_strobe = 1'b0;
    endtask

    task automatic idle_cycle(input logic [7:0] h, input logic [7:0] l);
        valid = 1'b0; hi = h; lo = l; rnw = 1'($urandom); din = 8'($urandom);
        #1;
        chk("idle_ready", 32'(rdy), 32'd1);
        chk("idle_oe", 32'(oe), 32'd0);
        chk("idle_dout", 32'(dout), 32'd0);
        chk("idle_strobe", 32'(stb), 32'(m_strobe));
        chk("idle_widx", 32'(wi), 32'(m_widx[sel]));
        m_strobe = 1'b0;
        @(negedge clk);
    endtask

    // CPU-side cycle: holds the request until ready, drives write data in the completing cycle.
    task automatic access(input logic [7:0] h, input logic [7:0] l, input logic r,
                          input logic [7:0] wd, input logic chg, input logic [7:0] alt);
        int         ws;
        int         lowcnt;
        logic       is_hit;
        logic [3:0] idx;
        ws     = ws_tab[sel];
        is_hit = (h == 8'hD0) && (l[7:4] == 4'h0);
        idx    = l[3:0];
        hi = h; lo = l; rnw = r; valid = 1'b1;
        din = (ws > 0) ? ~wd : wd;
        #1;
        chk("strobe_prev", 32'(stb), 32'(m_strobe));
        chk("widx_prev", 32'(wi), 32'(m_widx[sel]));
        lowcnt = 0;
        for (int k = 0; k < 20 && rdy !== 1'b1; k++) begin
            lowcnt++;
            @(negedge clk);
            if (chg) begin
                lo  = alt;
                rnw = ~r;
            end
            #1;
        end
        chk("ready_low_cycles", 32'(lowcnt), is_hit ? 32'(ws) : 32'd0);
        din = wd;
        chk("data_oe", 32'(oe), 32'(is_hit && r));
        chk("data_out", 32'(dout), (is_hit && r) ? 32'(m_bank[sel][idx]) : 32'd0);
        @(negedge clk);
        if (is_hit && !r) begin
            m_bank[sel][idx] = wd;
            m_widx[sel]      = idx;
            m_strobe         = 1'b1;
        end else begin
            m_strobe = 1'b0;
        end
    endtask

    task automatic abort_write(input logic [7:0] l, input logic [7:0] wd);
        hi = 8'hD0; lo = l; rnw = 1'b0; valid = 1'b1; din = wd;
        #1;
        chk("abort_req_ready", 32'(rdy), 32'd0);
        chk("abort_strobe_prev", 32'(stb), 32'(m_strobe));
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk("abort_wait_ready", 32'(rdy), 32'd0);
        @(negedge clk);
        m_strobe = 1'b0;
    endtask

    task automatic random_traffic(input int n);
        logic [7:0] h, l;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_cycle(8'($urandom), 8'($urandom));
            end else begin
                h = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hD0;
                l = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
                access(h, l, 1'($urandom), 8'($urandom), 1'b0, 8'h00);
            end
        end
    endtask

    initial begin
        model_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_ready", 32'(rdy), 32'd1);
            chk("reset_oe", 32'(oe), 32'd0);
            chk("reset_dout", 32'(dout), 32'd0);
            chk("reset_strobe", 32'(stb), 32'd0);
            chk("reset_widx", 32'(wi), 32'd0);
        end
        sel = 0;
        @(negedge clk);
        nrst = 1'b1;
        idle_cycle(8'hD0, 8'h05);

        access(8'hD0, 8'h05, 1'b0, 8'hA5, 1'b0, 8'h00);
        access(8'hD0, 8'h05, 1'b1, 8'h00, 1'b0, 8'h00);
        access(8'hC0, 8'h05, 1'b0, 8'h11, 1'b0, 8'h00);
        access(8'hD0, 8'h15, 1'b0, 8'h22, 1'b0, 8'h00);
        idle_cycle(8'hD0, 8'h05);
        access(8'hD0, 8'h05, 1'b1, 8'h00, 1'b0, 8'h00);

        access(8'hD0, 8'h07, 1'b0, 8'h99, 1'b0, 8'h00);
        abort_write(8'h02, 8'h3C);
        idle_cycle(8'hD0, 8'h02);
        access(8'hD0, 8'h02, 1'b1, 8'h00, 1'b1, 8'h07);
        access(8'hD0, 8'h07, 1'b1, 8'h00, 1'b0, 8'h00);

        hi = 8'hD0; lo = 8'h05; rnw = 1'b0; valid = 1'b1; din = 8'h77;
        #1;
        chk("rst_req_ready", 32'(rdy), 32'd0);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(rdy), 32'd1);
        chk("rst_mid_oe", 32'(oe), 32'd0);
        chk("rst_mid_dout", 32'(dout), 32'd0);
        chk("rst_mid_strobe", 32'(stb), 32'd0);
        chk("rst_mid_widx", 32'(wi), 32'd0);
        valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
        idle_cycle(8'h00, 8'h00);
        access(8'hD0, 8'h05, 1'b1, 8'h00, 1'b0, 8'h00);
        random_traffic(40);
        idle_cycle(8'h00, 8'h00);

        sel = 1;
        idle_cycle(8'hD0, 8'h0F);
        access(8'hD0, 8'h0F, 1'b0, 8'h5A, 1'b0, 8'h00);
        access(8'hD0, 8'h0F, 1'b1, 8'h00, 1'b0, 8'h00);
        random_traffic(40);
        idle_cycle(8'h00, 8'h00);

        sel = 2;
        idle_cycle(8'hD0, 8'h00);
        access(8'hD0, 8'h00, 1'b0, 8'h61, 1'b0, 8'h00);
        access(8'hD0, 8'h01, 1'b0, 8'h62, 1'b0, 8'h00);
        idle_cycle(8'h00, 8'h00);
        access(8'hD0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);
        access(8'hD0, 8'h01, 1'b1, 8'h00, 1'b0, 8'h00);
        random_traffic(40);
        idle_cycle(8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
